// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared mode encodings for the immediate-extension stage.
// Mode 3 means BRANCH when IMM_EXT_BRANCH_EN is defined, and illegal otherwise.
package imm_ext_pkg;

  localparam int IMM_MODE_W = 2;

  typedef logic [IMM_MODE_W-1:0] imm_mode_t;

  localparam imm_mode_t MODE_ZERO   = 2'd0;
  localparam imm_mode_t MODE_SIGN   = 2'd1;
  localparam imm_mode_t MODE_UPPER  = 2'd2;
  localparam imm_mode_t MODE_BRANCH = 2'd3;

endpackage

// File: rtl/imm_ext_if.sv
// imm_ext_if: valid/ready bus for the immediate-extension stage.
// The decode side uses master; the stage uses slave.
interface imm_ext_if
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  imm_mode_t        in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_illegal;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_illegal
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_illegal
  );

endinterface

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extender (zero / sign / upper / branch).
// Configuration macro: IMM_EXT_BRANCH_EN.
//   Defined: mode 3 produces a sign-extended offset shifted left by 2.
//   Undefined: mode 3 flags the beat as illegal and produces zero.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_imm,
  input  imm_mode_t        in_mode,
  output logic [OUT_W-1:0] data,
  output logic             illegal
);

  logic [OUT_W-1:0] sext_imm;

  assign sext_imm = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  // Select the extended value for the requested mode.
  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (in_mode)
      MODE_ZERO:  data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      MODE_SIGN:  data = sext_imm;
      MODE_UPPER: data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default: begin
`ifdef IMM_EXT_BRANCH_EN
        data    = sext_imm << 2;
        illegal = 1'b0;
`else
        data    = '0;
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered immediate-extension stage with a two-entry skid buffer.
// The mode 3 behaviour of the extender depends on the IMM_EXT_BRANCH_EN macro.
// in_ready comes only from the skid valid register, so it never depends on out_ready.
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  imm_ext_if.slave  bus
);

  logic [OUT_W-1:0] core_data;
  logic             core_illegal;

  logic             main_valid, skid_valid;
  logic [OUT_W-1:0] main_data, skid_data;
  logic             main_illegal, skid_illegal;

  logic             in_ready_int;
  logic             accept, deliver;
  logic             main_valid_d, skid_valid_d;
  logic             main_load_in, main_load_skid, skid_load;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm  (bus.in_imm),
    .in_mode (bus.in_mode),
    .data    (core_data),
    .illegal (core_illegal)
  );

  assign in_ready_int    = !skid_valid && !reset;
  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = main_valid;
  assign bus.out_data    = main_data;
  assign bus.out_illegal = main_illegal;

  // Decide where an accepted beat goes and how the valid bits move this cycle.
  always_comb begin
    accept         = bus.in_valid && in_ready_int && !flush;
    deliver        = main_valid && bus.out_ready;
    main_valid_d   = main_valid;
    skid_valid_d   = skid_valid;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (deliver && skid_valid) begin
      main_load_skid = 1'b1;
      main_valid_d   = 1'b1;
      skid_valid_d   = 1'b0;
    end else if (accept && (!main_valid || deliver)) begin
      main_load_in = 1'b1;
      main_valid_d = 1'b1;
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end else if (deliver) begin
      main_valid_d = 1'b0;
    end
  end

  // Valid bits: cleared by reset, otherwise follow the routing decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  // Main result register: loads either the fresh extension or the skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data    <= '0;
      main_illegal <= 1'b0;
    end else if (main_load_skid) begin
      main_data    <= skid_data;
      main_illegal <= skid_illegal;
    end else if (main_load_in) begin
      main_data    <= core_data;
      main_illegal <= core_illegal;
    end
  end

  // Skid register: captures the extra beat that arrives while main is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data    <= '0;
      skid_illegal <= 1'b0;
    end else if (skid_load) begin
      skid_data    <= core_data;
      skid_illegal <= core_illegal;
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed and randomized bench for imm_ext_stage with a queue-based model.
// The model treats the stage as a 2-deep FIFO of extended values and computes those
// values from the mode rules using plain integer arithmetic.
module tb_imm_ext_stage;

  logic clk;
  logic reset;
  logic flush;

  imm_ext_if #(.IN_W(16), .OUT_W(32)) bus ();

  imm_ext_stage #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] d;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   nAccepted   = 0;
  int   nDelivered  = 0;
  bit   modelAcc, modelDel;
  exp_t modelEntry;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelExt(input logic [15:0] imm, input logic [1:0] mode,
                                   output logic [31:0] d, output logic ill);
    int s;
    s   = imm[15] ? int'(imm) - 65536 : int'(imm);
    ill = 1'b0;
    case (mode)
      2'd0:    d = 32'(imm);
      2'd1:    d = 32'(s);
      2'd2:    d = 32'(imm) * 32'd65536;
      default: begin
`ifdef IMM_EXT_BRANCH_EN
        d = 32'(s * 4);
`else
        d   = 32'd0;
        ill = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                               input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_imm    = imm;
    bus.in_mode   = mode;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  // Model: a 2-deep FIFO that accepts when not full and delivers its head when ready.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      modelAcc = bus.in_valid && (q.size() < 2) && !flush;
      modelDel = bus.out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (modelDel) begin
          void'(q.pop_front());
          nDelivered++;
        end
        if (modelAcc) begin
          modelExt(bus.in_imm, bus.in_mode, modelEntry.d, modelEntry.ill);
          q.push_back(modelEntry);
          nAccepted++;
        end
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("in_ready_during_reset", 32'(bus.in_ready), 32'd0);
      checkOutput("out_valid_during_reset", 32'(bus.out_valid), 32'd0);
    end else begin
      checkOutput("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        checkOutput("out_data", bus.out_data, q[0].d);
        checkOutput("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
      end
    end
  end

  initial begin
    int base;
    int cycles;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", bus.out_data, 32'd0);
    checkOutput("reset_out_illegal", 32'(bus.out_illegal), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] basic modes");
    applyStimulus(1'b1, 16'h8001, 2'd0, 1'b1, 1'b0);
    checkOutput("zero_8001", bus.out_data, 32'h00008001);
    applyStimulus(1'b1, 16'h8001, 2'd1, 1'b1, 1'b0);
    checkOutput("sign_8001", bus.out_data, 32'hFFFF8001);
    applyStimulus(1'b1, 16'h8001, 2'd2, 1'b1, 1'b0);
    checkOutput("upper_8001", bus.out_data, 32'h80010000);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 16'h0001, 2'd0, 1'b0, 1'b0);
    checkOutput("bp_ready_after_1", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 16'h0002, 2'd0, 1'b0, 1'b0);
    checkOutput("bp_ready_after_2", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 16'h0003, 2'd0, 1'b0, 1'b0);
    checkOutput("bp_hold_data", bus.out_data, 32'h00000001);
    applyStimulus(1'b1, 16'h0003, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_second", bus.out_data, 32'h00000002);
    checkOutput("bp_ready_back", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 16'h0003, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_third", bus.out_data, 32'h00000003);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

    $display("[TB] mode 3");
    applyStimulus(1'b1, 16'hFFFF, 2'd3, 1'b1, 1'b0);
`ifdef IMM_EXT_BRANCH_EN
    checkOutput("branch_data", bus.out_data, 32'hFFFFFFFC);
    checkOutput("branch_illegal", 32'(bus.out_illegal), 32'd0);
`else
    checkOutput("illegal_data", bus.out_data, 32'h00000000);
    checkOutput("illegal_flag", 32'(bus.out_illegal), 32'd1);
`endif
    applyStimulus(1'b1, 16'h0005, 2'd0, 1'b1, 1'b0);
    checkOutput("after_m3_illegal", 32'(bus.out_illegal), 32'd0);
    checkOutput("after_m3_data", bus.out_data, 32'h00000005);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 16'h0011, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0022, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0033, 2'd0, 1'b0, 1'b1);
    checkOutput("flush_full_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_full_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 16'h0044, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0055, 2'd0, 1'b0, 1'b1);
    checkOutput("flush_open_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 16'h0066, 2'd0, 1'b1, 1'b0);
    checkOutput("flush_next_data", bus.out_data, 32'h00000066);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    checkOutput("flush_drained", 32'(bus.out_valid), 32'd0);

    $display("[TB] async reset");
    applyStimulus(1'b1, 16'h0077, 2'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_out_data", bus.out_data, 32'd0);
    checkOutput("async_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 16'h7FFF, 2'd1, 1'b1, 1'b0);
    checkOutput("sign_7fff", bus.out_data, 32'h00007FFF);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    base   = nDelivered;
    cycles = 0;
    while ((nDelivered - base) < 1000 && cycles < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom),
                    $urandom_range(0, 2) != 0, 1'b0);
      cycles++;
    end
    checkOutput("random_beats_delivered", 32'((nDelivered - base) >= 1000), 32'd1);
    repeat (3) applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
    checkOutput("random_drained", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Parametrised, registered immediate-extension stage for the pipelined MIPS datapath, sitting between decode and the ID/EX register. It accepts an IN_W-bit immediate plus a mode and delivers an OUT_W-bit extended operand: zero-extend, sign-extend, upper-load placement, or optionally branch offset. A valid/ready handshake with a two-entry skid buffer sustains one result per cycle under back-pressure, with synchronous flush for branch/exception squash.

## Interface
- IN_W, default 16: immediate width; must be at least 2.
- OUT_W, default 32: result width; must be at least 2*IN_W so UPPER mode fits.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept a beat.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  0=ZERO, 1=SIGN, 2=UPPER, 3=BRANCH or illegal.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  OUT_W  extended immediate.
- out_illegal  out  1  the current beat carried an unsupported mode.

## Operation
- Extension is computed on the input side. The output register stores the computed value, not the raw immediate.
- ZERO: IN_W input bits, upper bits 0.
- SIGN: upper bits replicate in_imm[IN_W-1].
- UPPER: in_imm placed at [OUT_W-1 : OUT_W-IN_W]; all lower bits 0.
- Mode 3 depends on the configuration; see Configuration.
- Storage:
  - main register: drives out_*.
  - skid register: holds one extra beat.
- Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
- Accepted beat routing:
  - goes to main if main is empty, or main is delivering in the same cycle with skid empty;
  - otherwise goes to skid.
- Delivery with skid full: skid moves to main in the same edge, and skid becomes empty.
- in_ready = !skid_valid, taken from a register. It is never combinational from out_ready.
- Order is strictly FIFO. No beat is dropped or duplicated except by flush.
- Flush has priority over everything:
  - main_valid and skid_valid clear at the next edge;
  - a beat presented in the flush cycle is discarded;
  - data registers keep their values; only the valid bits matter.

## Timing
- Latency: accept at edge N gives out_valid high after edge N, with main previously empty.
- Throughput: 1 beat per cycle while out_ready stays high.
- Back-pressure:
  - main full and out_ready low: one more beat is absorbed into skid;
  - in_ready falls after that edge.
- in_ready returns high the cycle after the delivery that empties skid.
- Reset (asynchronous assert):
  - out_valid=0, out_data=0, out_illegal=0;
  - skid_valid=0, so in_ready=1 once reset is released. In_ready reads 0 while reset is high.
- Reset mid-operation loses all held beats. No partial state survives.
- out_data and out_illegal stay stable while out_valid && !out_ready.
- Simultaneous accept and deliver with skid full cannot happen, because in_ready is low.

## Configuration
- Macro IMM_EXT_BRANCH_EN.
- Defined: mode 3 = BRANCH. Result = sign-extended in_imm shifted left 2, with the low 2 bits 0. out_illegal is always 0.
- Undefined: mode 3 is illegal. out_data = 0 and out_illegal = 1 for that beat only. The handshake is unaffected.

## Structure
- Package imm_ext_pkg:
  - mode localparams MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_BRANCH;
  - mode width constant IMM_MODE_W = 2.
- Sub-module imm_ext_core: purely combinational extender (in_imm, in_mode → data, illegal), parametrised by IN_W/OUT_W, instantiated once at the input.
- imm_ext_stage holds the main and skid registers and the handshake control.

## Test plan
- Reset, then send modes 0/1/2 with in_imm=16'h8001 and out_ready=1:
  - outputs 32'h00008001, 32'hFFFF8001, 32'h80010000 on consecutive cycles;
  - latency 1 cycle.
- out_ready=0, then push 3 beats (16'h0001, 16'h0002, 16'h0003, mode ZERO):
  - first two are accepted; in_ready drops after the second;
  - raise out_ready: results 1, 2, 3 appear in order with no loss.
- Mode 3 with in_imm=16'hFFFF:
  - with IMM_EXT_BRANCH_EN: out_data=32'hFFFFFFFC, out_illegal=0;
  - without: out_data=0, out_illegal=1 for that beat only.
- Main and skid full; assert flush together with in_valid:
  - next cycle out_valid=0 and in_ready=1;
  - the flushed beat never appears.
- Assert reset asynchronously mid-stream between clock edges:
  - out_valid falls immediately; out_data=0;
  - after release, a new beat 16'h7FFF in SIGN mode gives 32'h00007FFF.
- Random valid/ready toggling at full rate over 1000 beats, checked by a scoreboard: in-order, bit-exact, no duplicates.
